// File: rtl/freq_counter_top.sv
// Single-channel frequency/duty meter: gated edge and high-time counting, divider plus
// double-dabble conversion, and a scanned 8-digit display driven through two 74HC595s.
module freq_counter_top #(
  parameter int CLK_FREQ    = 50000000,
  parameter int GATE_CYCLES = CLK_FREQ,
  parameter int SCLK_HALF   = 2,
  parameter int SCAN_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic signal_in,
  output logic rclk,
  output logic sclk,
  output logic dio
);

  // Conversion sequencer
  // state  | meaning
  // C_IDLE | waiting for conv_start
  // C_DIV  | restoring divide of high time * 100 by the gate length
  // C_PREP | clamp duty, load binary operands for BCD
  // C_BCD  | double-dabble, freq and duty in parallel
  // C_DONE | atomically publish both results to the display
  //
  // Serialiser
  // state   | meaning
  // S_IDLE  | no frame in progress
  // S_LOW   | sclk low, dio carries the current bit
  // S_HIGH  | sclk high, shift register clocks the bit
  // S_LATCH | rclk high, frame moved to the output stage

  localparam int DIV_W = 39;
  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam int HALF_W = $clog2(SCLK_HALF + 1);
  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);
  localparam logic [32:0] DIVISOR = 33'(GATE_CYCLES);
  localparam logic [31:0] DIVISOR_LO = 32'(GATE_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCLK_HALF - 1);

  typedef enum logic [2:0] {C_IDLE, C_DIV, C_PREP, C_BCD, C_DONE} cnv_state_t;
  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOW   = 3'b001,
    S_HIGH  = 3'b010,
    S_LATCH = 3'b100
  } ser_state_t;

  function automatic logic [23:0] dd_adj6(input logic [23:0] b);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < 6; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] dd_adj2(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < 2; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  logic s1, s2, s3, rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= signal_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  logic [31:0] gate_tmr, edge_cnt, high_cnt, edge_sum, high_sum, high_latch;
  logic [19:0] freq_latch;
  logic        conv_start;

  assign edge_sum = edge_cnt + 32'(rise);
  assign high_sum = high_cnt + 32'(s2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_tmr   <= GATE_LAST;
      edge_cnt   <= '0;
      high_cnt   <= '0;
      freq_latch <= '0;
      high_latch <= '0;
      conv_start <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      if (gate_tmr == '0) begin
        gate_tmr   <= GATE_LAST;
        edge_cnt   <= '0;
        high_cnt   <= '0;
        freq_latch <= (edge_sum > 32'd999999) ? 20'd999999 : edge_sum[19:0];
        high_latch <= high_sum;
        conv_start <= 1'b1;
      end else begin
        gate_tmr <= gate_tmr - 32'd1;
        edge_cnt <= edge_sum;
        high_cnt <= high_sum;
      end
    end
  end

  cnv_state_t cnv_state, cnv_next;
  logic [5:0]       step_cnt;
  logic [31:0]      rem, rem_next;
  logic [32:0]      rem_shift;
  logic             q_bit;
  logic [DIV_W-1:0] dvd;
  logic [6:0]       duty_q;
  logic [19:0]      fbin, dbin;
  logic [23:0]      fbcd, fbcd_adj;
  logic [7:0]       dbcd, dbcd_adj;
  logic [31:0]      disp_bcd;
  logic             div_load, div_step, bcd_load, bcd_step, disp_load;

  always_ff @(posedge clk) begin
    if (!rst_n) cnv_state <= C_IDLE;
    else        cnv_state <= cnv_next;
  end

  always_comb begin
    cnv_next = cnv_state;
    case (cnv_state)
      C_IDLE:  if (conv_start) cnv_next = C_DIV;
      C_DIV:   if (step_cnt == '0) cnv_next = C_PREP;
      C_PREP:  cnv_next = C_BCD;
      C_BCD:   if (step_cnt == '0) cnv_next = C_DONE;
      C_DONE:  cnv_next = C_IDLE;
      default: cnv_next = C_IDLE;
    endcase
  end

  always_comb begin
    div_load  = (cnv_state == C_IDLE) && conv_start;
    div_step  = (cnv_state == C_DIV);
    bcd_load  = (cnv_state == C_PREP);
    bcd_step  = (cnv_state == C_BCD);
    disp_load = (cnv_state == C_DONE);
  end

  assign rem_shift = {rem, dvd[DIV_W-1]};
  assign q_bit     = (rem_shift >= DIVISOR);
  assign rem_next  = q_bit ? (rem_shift[31:0] - DIVISOR_LO) : rem_shift[31:0];
  // Full-on input gives exactly 100 %, which the two-digit display cannot show.
  assign duty_q    = (dvd > DIV_W'(99)) ? 7'd99 : dvd[6:0];
  assign fbcd_adj  = dd_adj6(fbcd);
  assign dbcd_adj  = dd_adj2(dbcd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt <= '0;
      rem      <= '0;
      dvd      <= '0;
      fbin     <= '0;
      dbin     <= '0;
      fbcd     <= '0;
      dbcd     <= '0;
      disp_bcd <= '0;
    end else begin
      if (div_load) begin
        rem      <= '0;
        dvd      <= DIV_W'(high_latch) * DIV_W'(100);
        step_cnt <= 6'(DIV_W - 1);
      end else if (div_step) begin
        rem      <= rem_next;
        dvd      <= {dvd[DIV_W-2:0], q_bit};
        step_cnt <= step_cnt - 6'd1;
      end else if (bcd_load) begin
        fbin     <= freq_latch;
        dbin     <= 20'(duty_q);
        fbcd     <= '0;
        dbcd     <= '0;
        step_cnt <= 6'd19;
      end else if (bcd_step) begin
        fbcd     <= (fbcd_adj << 1) | 24'(fbin[19]);
        dbcd     <= (dbcd_adj << 1) | 8'(dbin[19]);
        fbin     <= fbin << 1;
        dbin     <= dbin << 1;
        step_cnt <= step_cnt - 6'd1;
      end
      if (disp_load) disp_bcd <= {fbcd, dbcd};
    end
  end

  ser_state_t ser_state, ser_next;
  logic [SCAN_W-1:0] scan_tmr;
  logic [2:0]        digit_idx;
  logic              frame_req, frame_go;
  logic [3:0]        digit_val;
  logic [15:0]       frame_word, shreg;
  logic [3:0]        bit_cnt;
  logic [HALF_W-1:0] ser_tmr;

  assign frame_go   = frame_req && (ser_state == S_IDLE);
  assign digit_val  = disp_bcd[{digit_idx, 2'b00} +: 4];
  assign frame_word = {seg_code(digit_val), 8'd1 << digit_idx};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_tmr  <= SCAN_LAST;
      digit_idx <= '0;
      frame_req <= 1'b1;
    end else if (scan_tmr == '0) begin
      scan_tmr  <= SCAN_LAST;
      digit_idx <= digit_idx + 3'd1;
      frame_req <= 1'b1;
    end else begin
      scan_tmr <= scan_tmr - SCAN_W'(1);
      if (frame_go) frame_req <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ser_state <= S_IDLE;
    else        ser_state <= ser_next;
  end

  always_comb begin
    ser_next = ser_state;
    case (ser_state)
      S_IDLE:  if (frame_req) ser_next = S_LOW;
      S_LOW:   if (ser_tmr == '0) ser_next = S_HIGH;
      S_HIGH:  if (ser_tmr == '0) ser_next = (bit_cnt == 4'd15) ? S_LATCH : S_LOW;
      S_LATCH: if (ser_tmr == '0) ser_next = S_IDLE;
      default: ser_next = S_IDLE;
    endcase
  end

  // sclk and rclk are single state bits so the pins cannot glitch on state changes.
  always_comb begin
    sclk = ser_state[1];
    rclk = ser_state[2];
    dio  = shreg[15];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      ser_tmr <= '0;
    end else if (frame_go) begin
      shreg   <= frame_word;
      bit_cnt <= '0;
      ser_tmr <= HALF_LAST;
    end else if (ser_state != S_IDLE) begin
      if (ser_tmr == '0) begin
        ser_tmr <= HALF_LAST;
        if (ser_state == S_HIGH) begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        ser_tmr <= ser_tmr - HALF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_freq_counter_top.sv
// Randomised bench for freq_counter_top: a windowed counting model predicts each gate's
// result, and a frame monitor decodes the 74HC595 stream and checks it against the queue.
module tb_freq_counter_top;

  localparam int G    = 1000;
  localparam int SCAN = 200;
  localparam int HALF = 2;

  typedef struct {
    int end_c;
    int freq;
    int duty;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signal_in = 1'b0;
  logic rclk, sclk, dio;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frames_seen = 0;
  res_t exp_q[$];
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  freq_counter_top #(
    .CLK_FREQ(1000000),
    .GATE_CYCLES(G),
    .SCLK_HALF(HALF),
    .SCAN_CYCLES(SCAN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .signal_in(signal_in),
    .rclk(rclk),
    .sclk(sclk),
    .dio(dio)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] frame_of(input res_t r, input int d);
    int v, p;
    p = 1;
    if (d >= 2) begin
      for (int i = 0; i < d - 2; i++) p = p * 10;
      v = (r.freq / p) % 10;
    end else begin
      v = (d == 1) ? (r.duty / 10) % 10 : r.duty % 10;
    end
    return {seg_tab[v], 8'(1 << d)};
  endfunction

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // Model: each gate covers G input samples, seen two clocks late through the synchroniser.
  initial begin
    int n, h_acc, e_acc;
    logic d1, d2, d3;
    res_t r;
    n = 0; h_acc = 0; e_acc = 0; d1 = 0; d2 = 0; d3 = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        n = 0; h_acc = 0; e_acc = 0; d1 = 0; d2 = 0; d3 = 0;
        exp_q.delete();
      end else begin
        h_acc += int'(d2);
        e_acc += int'(d2 & ~d3);
        d3 = d2; d2 = d1; d1 = signal_in;
        if ((n % G) == G - 1) begin
          r.end_c = cyc;
          r.freq = (e_acc > 999999) ? 999999 : e_acc;
          r.duty = (h_acc * 100 / G > 99) ? 99 : h_acc * 100 / G;
          exp_q.push_back(r);
          h_acc = 0;
          e_acc = 0;
        end
        n++;
      end
    end
  end

  // Monitor: decode frames from sclk/rclk/dio and compare against the expected display.
  initial begin
    logic p_sclk, p_rclk;
    logic [15:0] sh, want_new, want_old;
    int bits, fstart, fcnt, d, cur_t;
    logic amb;
    res_t cur, prv;
    p_sclk = 0; p_rclk = 0; sh = '0; bits = 0; fstart = 0; fcnt = 0;
    cur = '{0, 0, 0}; prv = cur; cur_t = -100000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bits = 0; fcnt = 0; cur = '{0, 0, 0}; prv = cur; cur_t = -100000;
        p_sclk = 0; p_rclk = 0;
      end else begin
        if (sclk && !p_sclk) begin
          if (bits == 0) fstart = cyc;
          sh = {sh[14:0], dio};
          bits++;
        end
        if (rclk && !p_rclk) begin
          total++;
          if (bits != 16) begin
            bad++;
            $display("FAIL frame_bits got=%0d want=16", bits);
          end
          while (exp_q.size() > 0 && exp_q[0].end_c < fstart) begin
            prv = cur;
            cur = exp_q.pop_front();
            cur_t = cur.end_c;
          end
          d = fcnt % 8;
          want_new = frame_of(cur, d);
          want_old = frame_of(prv, d);
          amb = (fstart - cur_t) <= 140;
          total++;
          if (!(sh == want_new || (amb && sh == want_old))) begin
            bad++;
            $display("FAIL frame digit=%0d got=%h want=%h (freq=%0d duty=%0d)",
                     d, sh, want_new, cur.freq, cur.duty);
          end
          fcnt++;
          frames_seen++;
          bits = 0;
        end
        p_sclk = sclk;
        p_rclk = rclk;
      end
    end
  end

  task automatic run_wave(input int period, input int high, input int cycles);
    int ph;
    ph = int'($urandom_range(0, period - 1));
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      signal_in = (ph < high);
      ph = (ph + 1 == period) ? 0 : ph + 1;
    end
  endtask

  task automatic run_noise(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      signal_in = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int per, hi, waited;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_bit("rst_rclk", rclk, 1'b0);
    check_bit("rst_sclk", sclk, 1'b0);
    check_bit("rst_dio", dio, 1'b0);
    rst_n = 1'b1;

    run_wave(100, 50, 3 * G);
    run_wave(100, 70, 3 * G);
    run_wave(100, 30, 3 * G);
    run_wave(20, 10, 3 * G);
    run_wave(1, 1, 3 * G);
    run_wave(1, 0, 3 * G);
    for (int k = 0; k < 4; k++) begin
      per = int'($urandom_range(2, 200));
      hi = int'($urandom_range(1, per - 1));
      run_wave(per, hi, 2500);
    end
    run_noise(2500);

    waited = 0;
    while (sclk !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (waited >= 500) begin
      bad++;
      $display("FAIL midframe_wait got=timeout want=sclk_high");
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_bit("midrst_rclk", rclk, 1'b0);
    check_bit("midrst_sclk", sclk, 1'b0);
    check_bit("midrst_dio", dio, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_wave(40, 13, 2000);
    repeat (100) @(negedge clk);

    total++;
    if (frames_seen < 140) begin
      bad++;
      $display("FAIL frame_count got=%0d want>=140", frames_seen);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
